// File: rtl/card_shoe_arbiter.sv
// Finite card shoe with round-robin draw arbitration: tracks per-value counts (2..11) and resolves random values to present cards.
// Optional CARD_SHOE_AUTO_RESHUFFLE_EN: reload the shoe before serving a request once cards_left <= RESHUF_THRESH.
module card_shoe_arbiter #(
  parameter int NREQ          = 2,
  parameter int DECKS         = 1,
  parameter int RESHUF_THRESH = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [4:0]      rng_val,
  input  logic            shuffle_req,
  output logic [NREQ-1:0] gnt,
  output logic [4:0]      card_val,
  output logic            card_valid,
  output logic            busy,
  output logic [7:0]      cards_left,
  output logic            reshuffle_due
);

  localparam int         PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [6:0] LOAD_LOW = 7'(4 * DECKS);
  localparam logic [6:0] LOAD_TEN = 7'(16 * DECKS);
  localparam logic [7:0] LOAD_ALL = 8'(52 * DECKS);
  localparam logic [7:0] THRESH   = 8'(RESHUF_THRESH);

  typedef enum logic [1:0] {ST_SHUFFLE, ST_IDLE, ST_DRAW, ST_SCAN} state_t;

  state_t          state_reg;
  logic [3:0]      ptr_reg;
  logic [PW-1:0]   last_reg;
  logic [PW-1:0]   win_reg;
  logic [NREQ-1:0] gnt_reg;
  logic [4:0]      card_val_reg;
  logic            card_valid_reg;
  logic            busy_reg;
  logic [7:0]      cards_left_reg;
  logic [6:0]      count_reg [10];

  logic            rng_in_range;
  logic [6:0]      rng_cnt;
  logic [6:0]      ptr_cnt;
  logic [3:0]      miss_ptr;
  logic [3:0]      ptr_wrap;
  logic            deliver;
  logic [3:0]      del_val;
  logic            any_req;
  logic            reload_on_req;
  logic [PW-1:0]   winner;
  logic [PW-1:0]   rr_idx;
  logic            rr_found;
  logic [NREQ-1:0] win_onehot;
  logic [9:0]      load_en;
  logic [9:0]      dec_en;

  assign rng_in_range = (rng_val >= 5'd2) && (rng_val <= 5'd11);

  always_comb begin
    rng_cnt = '0;
    ptr_cnt = '0;
    for (int i = 0; i < 10; i++) begin
      if (rng_val == 5'(i + 2)) rng_cnt = count_reg[i];
      if (ptr_reg == 4'(i + 2)) ptr_cnt = count_reg[i];
    end
  end

  always_comb begin
    if (!rng_in_range || rng_val == 5'd11) miss_ptr = 4'd2;
    else                                   miss_ptr = rng_val[3:0] + 4'd1;
  end

  assign ptr_wrap = (ptr_reg == 4'd11) ? 4'd2 : ptr_reg + 4'd1;

  // A hit in DRAW or SCAN delivers the card in the same edge.
  always_comb begin
    deliver = 1'b0;
    del_val = ptr_reg;
    if (state_reg == ST_DRAW && rng_in_range && rng_cnt != '0) begin
      deliver = 1'b1;
      del_val = rng_val[3:0];
    end else if (state_reg == ST_SCAN && ptr_cnt != '0) begin
      deliver = 1'b1;
      del_val = ptr_reg;
    end
  end

  // The granted requester still holds req during its gnt cycle; ignore it then.
  assign any_req = (|req) && !card_valid_reg;

`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
  assign reload_on_req = (cards_left_reg == 8'd0) || (cards_left_reg <= THRESH);
`else
  assign reload_on_req = (cards_left_reg == 8'd0);
`endif

  always_comb begin
    winner   = last_reg;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      rr_idx = PW'((int'(last_reg) + i) % NREQ);
      if (!rr_found && req[rr_idx]) begin
        winner   = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
      assign win_onehot[gi] = (win_reg == PW'(gi));
    end
    for (genvar gi = 0; gi < 10; gi++) begin : g_count_en
      assign load_en[gi] = (state_reg == ST_SHUFFLE) && (ptr_reg == 4'(gi + 2));
      assign dec_en[gi]  = deliver && (del_val == 4'(gi + 2)) && (count_reg[gi] != '0);
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < 10; i++) begin
      if (rst)             count_reg[i] <= '0;
      else if (load_en[i]) count_reg[i] <= (i == 8) ? LOAD_TEN : LOAD_LOW;
      else if (dec_en[i])  count_reg[i] <= count_reg[i] - 7'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_SHUFFLE;
      ptr_reg        <= 4'd2;
      last_reg       <= PW'(NREQ - 1);
      win_reg        <= '0;
      gnt_reg        <= '0;
      card_val_reg   <= '0;
      card_valid_reg <= 1'b0;
      busy_reg       <= 1'b1;
      cards_left_reg <= '0;
    end else begin
      gnt_reg        <= '0;
      card_valid_reg <= 1'b0;
      if (deliver) begin
        gnt_reg        <= win_onehot;
        card_valid_reg <= 1'b1;
        card_val_reg   <= {1'b0, del_val};
        last_reg       <= win_reg;
        if (cards_left_reg != 8'd0) cards_left_reg <= cards_left_reg - 8'd1;
        state_reg      <= ST_IDLE;
        busy_reg       <= 1'b0;
      end else begin
        case (state_reg)
          ST_SHUFFLE: begin
            if (ptr_reg == 4'd11) begin
              cards_left_reg <= LOAD_ALL;
              state_reg      <= ST_IDLE;
              busy_reg       <= 1'b0;
            end else begin
              ptr_reg <= ptr_reg + 4'd1;
            end
          end
          ST_IDLE: begin
            if (shuffle_req || (any_req && reload_on_req)) begin
              state_reg <= ST_SHUFFLE;
              ptr_reg   <= 4'd2;
              busy_reg  <= 1'b1;
            end else if (any_req) begin
              win_reg   <= winner;
              state_reg <= ST_DRAW;
              busy_reg  <= 1'b1;
            end
          end
          ST_DRAW: begin
            ptr_reg   <= miss_ptr;
            state_reg <= ST_SCAN;
          end
          ST_SCAN: ptr_reg <= ptr_wrap;
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign gnt           = gnt_reg;
  assign card_val      = card_val_reg;
  assign card_valid    = card_valid_reg;
  assign busy          = busy_reg;
  assign cards_left    = cards_left_reg;
  assign reshuffle_due = (cards_left_reg <= THRESH);

endmodule

// File: tb/tb_card_shoe_arbiter.sv
// Bench for card_shoe_arbiter: vector table, hand sequences for reset/depletion/empty/threshold, then random draws vs a shoe model.
module tb_card_shoe_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [4:0] rng_val;
  logic       shuffle_req;
  logic [1:0] gnt;
  logic [4:0] card_val;
  logic       card_valid;
  logic       busy;
  logic [7:0] cards_left;
  logic       reshuffle_due;

  always #5 clk = ~clk;

  card_shoe_arbiter #(.NREQ(2), .DECKS(1), .RESHUF_THRESH(15)) dut (
    .clk(clk), .rst(rst), .req(req), .rng_val(rng_val), .shuffle_req(shuffle_req),
    .gnt(gnt), .card_val(card_val), .card_valid(card_valid), .busy(busy),
    .cards_left(cards_left), .reshuffle_due(reshuffle_due)
  );

`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  int n_pass  = 0;
  int n_total = 0;

  // Shoe model: per-value counts, total left, last granted requester.
  int mcnt [12];
  int mleft;
  int mlast;

  typedef struct {
    logic [1:0] rq;
    int         rng;
    int         g;
    int         card;
    int         left;
    int         lat;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic void m_reload();
    for (int v = 2; v <= 11; v++) mcnt[v] = (v == 10) ? 16 : 4;
    mleft = 52;
  endfunction

  function automatic void m_draw(input logic [1:0] rq, input int rng, input bit sh,
                                 output int eg, output int ecard, output int elat);
    int w;
    int p;
    elat = 2;
    if (sh || mleft == 0 || (AUTO && mleft <= 15)) begin
      m_reload();
      elat += 11;
    end
    w = mlast;
    for (int i = 1; i <= 2; i++) begin
      if (rq[(mlast + i) % 2] && w == mlast) begin
        w = (mlast + i) % 2;
        break;
      end
    end
    if (rng >= 2 && rng <= 11 && mcnt[rng] > 0) begin
      ecard = rng;
    end else begin
      p = (rng >= 2 && rng <= 11) ? ((rng == 11) ? 2 : rng + 1) : 2;
      elat++;
      while (mcnt[p] == 0) begin
        p = (p == 11) ? 2 : p + 1;
        elat++;
      end
      ecard = p;
    end
    mcnt[ecard]--;
    mleft--;
    mlast = w;
    eg = 1 << w;
  endfunction

  task automatic do_reset();
    bit busy_ok;
    rst = 1'b1; req = 2'b00; shuffle_req = 1'b0; rng_val = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_valid", int'(card_valid), 0);
    chk("rst_card_val", int'(card_val), 0);
    chk("rst_cards_left", int'(cards_left), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_reshuffle_due", int'(reshuffle_due), 1);
    rst = 1'b0;
    busy_ok = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      if (!busy) busy_ok = 1'b0;
    end
    chk("busy_during_shuffle", int'(busy_ok), 1);
    @(posedge clk); #1;
    chk("load_busy", int'(busy), 0);
    chk("load_cards_left", int'(cards_left), 52);
    chk("load_reshuffle_due", int'(reshuffle_due), 0);
    m_reload();
    mlast = 1;
    $display("reset: cards_left=%0d busy=%0d", cards_left, busy);
  endtask

  // Present a request, wait for the grant, keep req for the gnt cycle, then drop the granted bit.
  task automatic run_draw(input logic [1:0] rq, input logic [4:0] rng, input logic sh,
                          output int g, output int cv, output int cl, output int lat, output int due);
    bit got;
    req = rq; rng_val = rng; shuffle_req = sh;
    got = 1'b0; lat = 0; g = 0; cv = 0; cl = 0; due = 0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(posedge clk); #1;
      shuffle_req = 1'b0;
      lat++;
      if (card_valid) begin
        got = 1'b1;
        g = int'(gnt); cv = int'(card_val); cl = int'(cards_left); due = int'(reshuffle_due);
      end
    end
    if (!got) chk("draw_timeout", 0, 1);
    @(posedge clk); #1;
    chk("valid_one_cycle", int'(card_valid), 0);
    req = req & ~2'(g);
  endtask

  task automatic model_txn(input logic [1:0] rq, input int rng, input bit sh);
    int eg, ec, el, g, cv, cl, lat, due;
    m_draw(rq, rng, sh, eg, ec, el);
    run_draw(rq, 5'(rng), sh, g, cv, cl, lat, due);
    chk("m_gnt", g, eg);
    chk("m_card", cv, ec);
    chk("m_left", cl, mleft);
    chk("m_lat", lat, el);
    chk("m_due", due, int'(mleft <= 15));
    $display("txn req=%b rng=%0d sh=%0d -> gnt=%b card=%0d left=%0d lat=%0d", rq, rng, sh, 2'(g), cv, cl, lat);
  endtask

  initial begin
    int eg, ec, el, g, cv, cl, lat, due;
    logic [1:0] rq;

    tbl[0] = '{rq: 2'b01, rng: 7,  g: 1, card: 7,  left: 51, lat: 2};
    tbl[1] = '{rq: 2'b11, rng: 7,  g: 2, card: 7,  left: 50, lat: 2};
    tbl[2] = '{rq: 2'b11, rng: 7,  g: 1, card: 7,  left: 49, lat: 2};
    tbl[3] = '{rq: 2'b11, rng: 7,  g: 2, card: 7,  left: 48, lat: 2};
    tbl[4] = '{rq: 2'b01, rng: 7,  g: 1, card: 8,  left: 47, lat: 3};
    tbl[5] = '{rq: 2'b10, rng: 0,  g: 2, card: 2,  left: 46, lat: 3};
    tbl[6] = '{rq: 2'b10, rng: 11, g: 2, card: 11, left: 45, lat: 2};
    tbl[7] = '{rq: 2'b01, rng: 31, g: 1, card: 2,  left: 44, lat: 3};
    tbl[8] = '{rq: 2'b01, rng: 10, g: 1, card: 10, left: 43, lat: 2};

    do_reset();

    for (int i = 0; i < 9; i++) begin
      m_draw(tbl[i].rq, tbl[i].rng, 1'b0, eg, ec, el);
      run_draw(tbl[i].rq, 5'(tbl[i].rng), 1'b0, g, cv, cl, lat, due);
      chk($sformatf("tbl%0d_gnt", i), g, tbl[i].g);
      chk($sformatf("tbl%0d_card", i), cv, tbl[i].card);
      chk($sformatf("tbl%0d_left", i), cl, tbl[i].left);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      $display("vec %0d req=%b rng=%0d -> gnt=%b card=%0d left=%0d lat=%0d", i, tbl[i].rq, tbl[i].rng, 2'(g), cv, cl, lat);
    end

    // Drain the remaining 11s, then an 11 must wrap the scan to value 2.
    for (int i = 0; i < 3; i++) model_txn(2'b01, 11, 1'b0);
    m_draw(2'b01, 11, 1'b0, eg, ec, el);
    run_draw(2'b01, 5'd11, 1'b0, g, cv, cl, lat, due);
    chk("depleted11_card", cv, 2);
    chk("depleted11_lat", lat, 3);
    chk("depleted11_left", cl, 39);
    $display("depleted 11 -> card=%0d lat=%0d left=%0d", cv, lat, cl);

`ifndef CARD_SHOE_AUTO_RESHUFFLE_EN
    while (mleft > 0) model_txn(2'($urandom_range(1, 3)), int'($urandom_range(0, 15)), 1'b0);
    m_draw(2'b01, 0, 1'b0, eg, ec, el);
    run_draw(2'b01, 5'd0, 1'b0, g, cv, cl, lat, due);
    chk("empty_card", cv, 2);
    chk("empty_lat", lat, 14);
    chk("empty_left", cl, 51);
    $display("empty shoe -> card=%0d lat=%0d left=%0d", cv, lat, cl);
`endif

    // Reset while a draw is in flight: no grant may escape.
    req = 2'b01; rng_val = 5'd7;
    @(posedge clk); #1;
    chk("abort_busy", int'(busy), 1);
    do_reset();

    for (int i = 0; i < 37; i++) model_txn(2'b01, 0, 1'b0);
    chk("thresh_left", int'(cards_left), 15);
    m_draw(2'b01, 11, 1'b0, eg, ec, el);
    run_draw(2'b01, 5'd11, 1'b0, g, cv, cl, lat, due);
    chk("thresh_card", cv, 11);
    chk("thresh_gnt", g, 1);
    chk("thresh_lat", lat, AUTO ? 13 : 2);
    chk("thresh_left_after", cl, AUTO ? 51 : 14);
    $display("threshold draw -> card=%0d lat=%0d left=%0d", cv, lat, cl);

    for (int i = 0; i < 120; i++) begin
      rq = req | 2'($urandom_range(0, 3));
      if (rq == 2'b00) rq = 2'b01 << $urandom_range(0, 1);
      model_txn(rq, int'($urandom_range(0, 15)), ($urandom_range(0, 19) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
